// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC job scheduler.
package mac_pkg;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_DW      = 8;
  localparam int DEF_AW      = 16;
  localparam int DEF_MAC_LAT = 2;

  // Scheduler phases: arbitrate, clear the MAC, stream beats, drain the pipe, hold result.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_STREAM,
    ST_DRAIN,
    ST_RESULT
  } sched_state_e;

endpackage

// File: rtl/mac_job_scheduler_if.sv
// Bundles the requester streams, the shared-MAC port and the result port.
interface mac_job_scheduler_if #(
  parameter int NREQ = 2,
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int IDW  = 1
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;

  logic               mac_r;
  logic [DW-1:0]      mac_a;
  logic [DW-1:0]      mac_b;
  logic [AW-1:0]      mac_acc;
  logic               mac_of;

  logic               res_valid;
  logic               res_ready;
  logic [AW-1:0]      res_acc;
  logic               res_of;
  logic [IDW-1:0]     res_id;

  // Scheduler side.
  modport slave (
    input  req_valid, req_last, req_a, req_b, mac_acc, mac_of, res_ready,
    output req_ready, mac_r, mac_a, mac_b, res_valid, res_acc, res_of, res_id
  );

  // Environment side: requesters, MAC and result consumer.
  modport master (
    output req_valid, req_last, req_a, req_b, mac_acc, mac_of, res_ready,
    input  req_ready, mac_r, mac_a, mac_b, res_valid, res_acc, res_of, res_id
  );

endinterface

// File: rtl/pipelined_mac.sv
// Two-stage multiply-accumulate: product register, then accumulator with sticky overflow.
module pipelined_mac #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          i_r,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [AW-1:0] o_acc,
  output logic          o_of
);

  logic [2*DW-1:0] r_prod;
  logic [AW-1:0]   r_acc;
  logic            r_of;
  logic [AW:0]     w_sum;

  assign w_sum = {1'b0, r_acc} + (AW+1)'(r_prod);

  // Multiply stage then accumulate stage; clear wipes both plus the overflow flag.
  always_ff @(posedge clk) begin
    if (i_r) begin
      r_prod <= '0;
      r_acc  <= '0;
      r_of   <= 1'b0;
    end else begin
      r_prod <= {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
      r_acc  <= w_sum[AW-1:0];
      r_of   <= r_of | w_sum[AW];
    end
  end

  assign o_acc = r_acc;
  assign o_of  = r_of;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_id,
  output logic            o_valid
);

  logic w_found;

  // Scan from the pointer upward and take the first active request.
  always_comb begin
    // NOTE: every output gets a default before the scan so no path leaves one unassigned (no latch).
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[idx]) begin
        w_found    = 1'b1;
        o_gnt[idx] = 1'b1;
        o_id       = IDW'(idx);
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/mac_job_scheduler.sv
// Time-shares one pipelined MAC between NREQ requesters, one whole dot-product job at a time.
module mac_job_scheduler
  import mac_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int IDW     = $clog2(NREQ)
) (
  input logic                clk,
  input logic                r,
  mac_job_scheduler_if.slave bus
);

  // Drain counter must hold MAC_LAT (MAC_LAT >= 1).
  localparam int CW = $clog2(MAC_LAT + 1);

  sched_state_e    r_state, w_next;

  logic [NREQ-1:0] r_grant_oh;
  logic [IDW-1:0]  r_grant_id;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_mac_a, r_mac_b;
  logic [AW-1:0]   r_res_acc;
  logic            r_res_of;
  logic [IDW-1:0]  r_res_id;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IDW-1:0]  w_arb_id;
  logic            w_arb_valid;
  logic            w_hs, w_last, w_res_hs, w_drain_done;
  logic [DW-1:0]   w_sel_a, w_sel_b;
  logic [NREQ-1:0] w_req_ready;
  logic            w_mac_r, w_res_valid;
  logic [IDW-1:0]  w_ptr_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_id    (w_arb_id),
    .o_valid (w_arb_valid)
  );

  // Only the granted lane is ever looked at; other requesters' valid/last are ignored.
  assign w_sel_a      = bus.req_a[int'(r_grant_id)*DW +: DW];
  assign w_sel_b      = bus.req_b[int'(r_grant_id)*DW +: DW];
  assign w_hs         = (r_state == ST_STREAM) && |(bus.req_valid & r_grant_oh);
  assign w_last       = |(bus.req_last & r_grant_oh);
  assign w_drain_done = (r_state == ST_DRAIN) && (r_cnt == '0);
  assign w_res_hs     = (r_state == ST_RESULT) && bus.res_ready;
  assign w_ptr_next   = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + IDW'(1);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (r) r_state <= ST_IDLE;
    else   r_state <= w_next;
  end

  // Next-state and per-state outputs.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_mac_r     = 1'b0;
    w_res_valid = 1'b0;
    unique case (r_state)
      ST_IDLE:   if (w_arb_valid) w_next = ST_CLR;
      ST_CLR: begin
        w_mac_r = 1'b1;
        w_next  = ST_STREAM;
      end
      ST_STREAM: begin
        w_req_ready = r_grant_oh;
        if (w_hs && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN:  if (w_drain_done) w_next = ST_RESULT;
      ST_RESULT: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Grant latch, MAC operand register, drain counter, result capture and RR pointer.
  always_ff @(posedge clk) begin
    if (r) begin
      r_grant_oh <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_mac_a    <= '0;
      r_mac_b    <= '0;
      r_res_acc  <= '0;
      r_res_of   <= 1'b0;
      r_res_id   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_arb_valid) begin
        r_grant_oh <= w_arb_gnt;
        r_grant_id <= w_arb_id;
      end

      // Accepted beats go to the MAC next cycle; anything else feeds zeros, which add nothing.
      r_mac_a <= w_hs ? w_sel_a : '0;
      r_mac_b <= w_hs ? w_sel_b : '0;

      if (w_hs && w_last)                    r_cnt <= CW'(MAC_LAT);
      else if (r_state == ST_DRAIN && r_cnt != '0) r_cnt <= r_cnt - CW'(1);

      if (w_drain_done) begin
        r_res_acc <= bus.mac_acc;
        r_res_of  <= bus.mac_of;
        r_res_id  <= r_grant_id;
      end

      if (w_res_hs) r_ptr <= w_ptr_next;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.mac_r     = w_mac_r;
  assign bus.mac_a     = r_mac_a;
  assign bus.mac_b     = r_mac_b;
  assign bus.res_valid = w_res_valid;
  assign bus.res_acc   = r_res_acc;
  assign bus.res_of    = r_res_of;
  assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Scheduler + pipelined MAC with a result scoreboard and a MAC-operand monitor.
module tb_mac_job_scheduler;
  import mac_pkg::*;

  localparam int NREQ    = 2;
  localparam int DW      = 8;
  localparam int AW      = 16;
  localparam int MAC_LAT = 2;
  localparam int IDW     = 1;

  typedef struct packed {
    logic [AW-1:0]  acc;
    logic           of;
    logic [IDW-1:0] id;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  res_t mon_e;

  logic          drv_valid [NREQ];
  logic          drv_last  [NREQ];
  logic [DW-1:0] drv_a     [NREQ];
  logic [DW-1:0] drv_b     [NREQ];
  logic          res_rdy;

  logic          hs_d;
  logic [DW-1:0] exp_a_d, exp_b_d;
  int            clr_count = 0;
  int            r1_bad = 0;
  logic          watch_r1 = 1'b0;

  mac_job_scheduler_if #(.NREQ(NREQ), .DW(DW), .AW(AW), .IDW(IDW)) bus ();

  mac_job_scheduler #(
    .NREQ(NREQ), .DW(DW), .AW(AW), .MAC_LAT(MAC_LAT), .IDW(IDW)
  ) dut (
    .clk (clk),
    .r   (rst),
    .bus (bus)
  );

  pipelined_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk   (clk),
    .i_r   (bus.mac_r | rst),
    .i_a   (bus.mac_a),
    .i_b   (bus.mac_b),
    .o_acc (bus.mac_acc),
    .o_of  (bus.mac_of)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = drv_valid[i];
      bus.req_last[i]         = drv_last[i];
      bus.req_a[i*DW +: DW]   = drv_a[i];
      bus.req_b[i*DW +: DW]   = drv_b[i];
    end
  end
  assign bus.res_ready = res_rdy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic expect_res(input int acc, input int of, input int id);
    res_t e;
    e.acc = acc[AW-1:0];
    e.of  = of[0];
    e.id  = id[IDW-1:0];
    sb.push_back(e);
  endtask

  // Result monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && res_rdy) begin
      if (sb.size() == 0) begin
        check("res_unexpected_valid", bus.res_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("res_acc", bus.res_acc, mon_e.acc);
        check("res_of",  bus.res_of,  mon_e.of);
        check("res_id",  bus.res_id,  mon_e.id);
      end
    end
  end

  // Operand monitor: mac_a/b carry the beat accepted one cycle earlier, else zero.
  always @(negedge clk) begin
    if (!rst) begin
      check("mac_a", bus.mac_a, hs_d ? exp_a_d : 8'd0);
      check("mac_b", bus.mac_b, hs_d ? exp_b_d : 8'd0);
      if (bus.mac_r) clr_count <= clr_count + 1;
      if (watch_r1 && bus.req_ready[1]) r1_bad <= r1_bad + 1;
    end
    hs_d <= 1'b0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (drv_valid[i] && bus.req_ready[i]) begin
          hs_d    <= 1'b1;
          exp_a_d <= drv_a[i];
          exp_b_d <= drv_b[i];
        end
      end
    end
  end

  task automatic drive_job(input int id, input int n, input logic [7:0] va [8],
                           input logic [7:0] vb [8], input int gap_at, input int gap_len);
    for (int k = 0; k < n; k++) begin
      int t   = 0;
      bit got = 1'b0;
      drv_valid[id] = 1'b1;
      drv_a[id]     = va[k];
      drv_b[id]     = vb[k];
      drv_last[id]  = (k == n - 1);
      while (!got && t < 200) begin
        @(negedge clk);
        got = bus.req_ready[id];
        @(posedge clk);
        t++;
      end
      #1;
      drv_valid[id] = 1'b0;
      drv_last[id]  = 1'b0;
      drv_a[id]     = '0;
      drv_b[id]     = '0;
      if (!got) begin
        check("beat_accept_timeout", 0, 1);
        return;
      end
      if (k == gap_at && gap_len > 0) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_results(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("results_drained", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_mac_r"},     bus.mac_r,     0);
    check({tag, "_mac_a"},     bus.mac_a,     0);
    check({tag, "_mac_b"},     bus.mac_b,     0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_acc"},   bus.res_acc,   0);
    check({tag, "_res_of"},    bus.res_of,    0);
    check({tag, "_res_id"},    bus.res_id,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    for (int i = 0; i < NREQ; i++) begin
      drv_valid[i] = 1'b0;
      drv_last[i]  = 1'b0;
      drv_a[i]     = '0;
      drv_b[i]     = '0;
    end
    res_rdy = 1'b1;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    // 1: req0 dot product = 54+20+18+24 = 116, one clear pulse, result 4 cycles after last beat.
    c0 = clr_count;
    expect_res(116, 0, 0);
    drive_job(0, 4, '{6, 5, 9, 3, 0, 0, 0, 0}, '{9, 4, 2, 8, 0, 0, 0, 0}, -1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 20);
    check("t1_res_latency", n, MAC_LAT + 2);
    wait_results(50);
    check("t1_clr_pulses", clr_count - c0, 1);

    // 2: req1 65025+1600 = 66625 wraps to 1089 with overflow.
    expect_res(1089, 1, 1);
    drive_job(1, 2, '{255, 40, 0, 0, 0, 0, 0, 0}, '{255, 40, 0, 0, 0, 0, 0, 0}, -1, 0);
    wait_results(100);

    // 3: simultaneous requests with pointer at 0: req0 (42+25+33=100) then req1 (4).
    expect_res(100, 0, 0);
    expect_res(4, 0, 1);
    watch_r1 = 1'b1;
    fork
      begin
        drive_job(0, 3, '{6, 5, 3, 0, 0, 0, 0, 0}, '{7, 5, 11, 0, 0, 0, 0, 0}, -1, 0);
        for (int k = 0; k < 30 && !bus.res_valid; k++) @(negedge clk);
        watch_r1 = 1'b0;
      end
      drive_job(1, 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    join
    wait_results(100);
    check("t3_r1_ready_during_job0", r1_bad, 0);

    // 4: scenario 1 with a 3-cycle bubble after the second beat; bubbles feed zeros.
    expect_res(116, 0, 0);
    drive_job(0, 4, '{6, 5, 9, 3, 0, 0, 0, 0}, '{9, 4, 2, 8, 0, 0, 0, 0}, 1, 3);
    wait_results(100);

    // 5: single-beat 7*3=21 held with res_ready low; req1 (2*5=10) waits until the handshake.
    res_rdy = 1'b0;
    expect_res(21, 0, 0);
    expect_res(10, 0, 1);
    fork
      drive_job(0, 1, '{7, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        drive_job(1, 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
      end
      begin
        for (int k = 0; k < 40 && !bus.res_valid; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          check("t5_hold_valid",     bus.res_valid, 1);
          check("t5_hold_acc",       bus.res_acc,   21);
          check("t5_hold_id",        bus.res_id,    0);
          check("t5_hold_of",        bus.res_of,    0);
          check("t5_hold_no_grant",  bus.req_ready, 0);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 res_rdy = 1'b1;
      end
    join
    wait_results(100);

    // Fairness: req0 issues two jobs back to back; req1's job is served between them.
    expect_res(1, 0, 0);
    expect_res(9, 0, 1);
    expect_res(4, 0, 0);
    fork
      begin
        drive_job(0, 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
        drive_job(0, 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
      end
      drive_job(1, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0}, -1, 0);
    join
    wait_results(150);

    // 6: reset mid-stream abandons the job; the following job is unaffected.
    drv_valid[0] = 1'b1;
    drv_a[0]     = 8'd6;
    drv_b[0]     = 8'd9;
    drv_last[0]  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[0] && n < 20);
    check("t6_streaming", bus.req_ready[0], 1);
    @(posedge clk);
    #1;
    drv_a[0] = 8'd5;
    drv_b[0] = 8'd4;
    rst      = 1'b1;
    drv_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    drv_a[0] = '0;
    drv_b[0] = '0;
    @(negedge clk);
    check_reset_outputs("t6_after_reset");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_no_result", bus.res_valid, 0);
    end
    @(posedge clk);
    #1;
    expect_res(116, 0, 1);
    drive_job(1, 4, '{6, 5, 9, 3, 0, 0, 0, 0}, '{9, 4, 2, 8, 0, 0, 0, 0}, -1, 0);
    wait_results(100);

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
